// File: rtl/hex_entry_ctrl_if.sv
// Debug write port between the hex entry controller and its target.
// The controller holds wr_req (with stable wr_addr/wr_data) until the
// target answers with wr_ack or the controller gives up.
interface hex_entry_ctrl_if;
  logic        wr_req;
  logic [15:0] wr_addr;
  logic [15:0] wr_data;
  logic        wr_ack;

  modport master (
    output wr_req,
    output wr_addr,
    output wr_data,
    input  wr_ack
  );

  modport slave (
    input  wr_req,
    input  wr_addr,
    input  wr_data,
    output wr_ack
  );
endinterface

// File: rtl/hex_entry_ctrl.sv
// Manual debug-write sequencer. Characters from a keyboard/UART are collected
// into a 4-character ASCII buffer that feeds an external hex decoder; the
// decoded value is taken first as an address, then as data, and the pair is
// issued as one request on the debug write port, aborted after TIMEOUT cycles.
module hex_entry_ctrl #(
  parameter int TIMEOUT = 1024,
  parameter int TCNT_W  = 11
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic [31:0]             buffer,
  input  logic [15:0]             disp_num,
  output logic [2:0]              digit_cnt,
  output logic [1:0]              field,
  hex_entry_ctrl_if.master        wr,
  output logic                    done,
  output logic                    bad_char,
  output logic                    timeout,
  output logic                    overrun
);

  typedef enum logic [1:0] {
    S_ADDR  = 2'd0,
    S_DATA  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  localparam logic [31:0] ZEROS   = 32'h3030_3030;
  localparam logic [7:0]  C_BS    = 8'h08;
  localparam logic [7:0]  C_ENTER = 8'h0D;
  localparam logic [7:0]  C_ESC   = 8'h1B;

  state_t            state;
  logic [TCNT_W-1:0] tcnt;
  logic              is_hex;
  logic [7:0]        hex_char;

  // The state encoding doubles as the field indicator, so field is registered.
  assign field = state;

  // Classify the incoming character and fold lowercase hex to uppercase.
  always_comb begin
    is_hex   = 1'b0;
    hex_char = rx_data;
    if ((rx_data >= 8'h30 && rx_data <= 8'h39) ||
        (rx_data >= 8'h41 && rx_data <= 8'h46)) begin
      is_hex = 1'b1;
    end else if (rx_data >= 8'h61 && rx_data <= 8'h66) begin
      is_hex   = 1'b1;
      hex_char = rx_data - 8'h20;
    end
  end

  // Entry state machine: character editing, field sequencing and write handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_ADDR;
      buffer     <= ZEROS;
      digit_cnt  <= 3'd0;
      wr.wr_req  <= 1'b0;
      wr.wr_addr <= 16'h0000;
      wr.wr_data <= 16'h0000;
      done       <= 1'b0;
      bad_char   <= 1'b0;
      timeout    <= 1'b0;
      overrun    <= 1'b0;
      tcnt       <= '0;
    end else begin
      done     <= 1'b0;
      bad_char <= 1'b0;
      timeout  <= 1'b0;
      case (state)
        S_ADDR, S_DATA: begin
          if (rx_valid) begin
            if (is_hex) begin
              if (digit_cnt < 3'd4) begin
                buffer    <= {buffer[23:0], hex_char};
                digit_cnt <= digit_cnt + 3'd1;
              end else begin
                bad_char <= 1'b1;
              end
            end else if (rx_data == C_BS) begin
              if (digit_cnt != 3'd0) begin
                buffer    <= {8'h30, buffer[31:8]};
                digit_cnt <= digit_cnt - 3'd1;
              end
            end else if (rx_data == C_ENTER) begin
              if (digit_cnt == 3'd4) begin
                if (state == S_ADDR) begin
                  wr.wr_addr <= disp_num;
                  buffer     <= ZEROS;
                  digit_cnt  <= 3'd0;
                  state      <= S_DATA;
                end else begin
                  wr.wr_data <= disp_num;
                  wr.wr_req  <= 1'b1;
                  tcnt       <= '0;
                  state      <= S_WRITE;
                end
              end else begin
                bad_char <= 1'b1;
              end
            end else if (rx_data == C_ESC) begin
              buffer    <= ZEROS;
              digit_cnt <= 3'd0;
              overrun   <= 1'b0;
              state     <= S_ADDR;
            end else begin
              bad_char <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          if (rx_valid) begin
            overrun <= 1'b1;
          end
          if (wr.wr_ack) begin
            wr.wr_req <= 1'b0;
            done      <= 1'b1;
            buffer    <= ZEROS;
            digit_cnt <= 3'd0;
            state     <= S_ADDR;
          end else if (tcnt == TCNT_W'(TIMEOUT - 1)) begin
            wr.wr_req <= 1'b0;
            timeout   <= 1'b1;
            buffer    <= ZEROS;
            digit_cnt <= 3'd0;
            state     <= S_ADDR;
          end else begin
            tcnt <= tcnt + TCNT_W'(1);
          end
        end
        default: begin
          state <= S_ADDR;
        end
      endcase
    end
  end

endmodule
